// File: rtl/riscv_pkg.sv
// Shared RV64IM decode definitions used by decode_issue and the ALU.
// Holds the major opcode constants, the 10-bit ALU opcode encoding
// ({funct3, major opcode}), the registered issue-bundle layout and a
// few small decode helpers.
package riscv_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;

  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_IMM32 = 7'h1B;
  localparam logic [6:0] OP       = 7'h33;
  localparam logic [6:0] OP32     = 7'h3B;

  typedef enum logic [9:0] {
    ALU_ADDI  = 10'h013, ALU_SLLI  = 10'h093, ALU_SLTI  = 10'h113,
    ALU_SLTIU = 10'h193, ALU_XORI  = 10'h213, ALU_SRLI  = 10'h293,
    ALU_ORI   = 10'h313, ALU_ANDI  = 10'h393,
    ALU_ADDIW = 10'h01B, ALU_SLLIW = 10'h09B, ALU_SRLIW = 10'h29B,
    ALU_ADD   = 10'h033, ALU_SLL   = 10'h0B3, ALU_SLT   = 10'h133,
    ALU_SLTU  = 10'h1B3, ALU_XOR   = 10'h233, ALU_SRL   = 10'h2B3,
    ALU_OR    = 10'h333, ALU_AND   = 10'h3B3,
    ALU_ADDW  = 10'h03B, ALU_SLLW  = 10'h0BB, ALU_SRLW  = 10'h2BB
  } alu_op_e;

  typedef struct packed {
    logic [9:0]      opcode;
    logic [4:0]      reg_a;
    logic [11:0]     reg_b;
    logic [4:0]      reg_dest;
    logic [XLEN-1:0] reg_a_value;
    logic [XLEN-1:0] reg_b_value;
    logic            illegal;
  } issue_bundle_t;

  // Major opcodes this stage can hand to the ALU.
  function automatic logic is_legal(input logic [6:0] op7);
    return (op7 == OP_IMM) || (op7 == OP_IMM32) || (op7 == OP) || (op7 == OP32);
  endfunction

  // Register-register forms are the only ones that read rs2.
  function automatic logic uses_rs2(input logic [6:0] op7);
    return (op7 == OP) || (op7 == OP32);
  endfunction

endpackage

// File: rtl/decode_issue_regfile.sv
// 32x64 integer register file: two asynchronous read ports, one
// synchronous write port, x0 reads as zero and ignores writes.
// With WB_BYPASS_EN defined, a same-cycle write is forwarded to a
// matching read port.
module decode_issue_regfile
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ra_addr,
  input  logic [4:0]      rb_addr,
  output logic [XLEN-1:0] ra_data,
  output logic [XLEN-1:0] rb_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_reg,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];
  logic            wr_live;

  assign wr_live = wb_en && (wb_reg != 5'd0);

  // Next register contents: apply the writeback, x0 never written.
  always_comb begin
    rf_d = rf_q;
    if (wr_live) rf_d[wb_reg] = wb_data;
  end

  // Storage, cleared on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Read ports with x0 forced to zero and optional writeback forwarding.
  always_comb begin
    ra_data = (ra_addr == 5'd0) ? '0 : rf_q[ra_addr];
    rb_data = (rb_addr == 5'd0) ? '0 : rf_q[rb_addr];
`ifdef WB_BYPASS_EN
    if (wr_live && (wb_reg == ra_addr)) ra_data = wb_data;
    if (wr_live && (wb_reg == rb_addr)) rb_data = wb_data;
`endif
  end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage feeding the ALU. Decodes RV64IM integer ALU
// instructions, reads operands, tracks outstanding destinations in a
// per-register scoreboard and registers the issue bundle (1-cycle
// latency, holds under backpressure).
// Optional macro WB_BYPASS_EN: forward same-cycle writeback data and
// let a dependent instruction issue in the writeback cycle.
module decode_issue
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic            wb_en,
  input  logic [4:0]      wb_reg,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [9:0]      opcode,
  output logic [4:0]      regA,
  output logic [11:0]     regB,
  output logic [4:0]      regDest,
  output logic [XLEN-1:0] regA_value,
  output logic [XLEN-1:0] regB_value,
  output logic            illegal
);

  logic [6:0]       op7;
  logic [4:0]       rs1, rs2, rd;
  logic             legal, use_rs1, use_rs2, hazard, accept;
  logic [XLEN-1:0]  rs1_val, rs2_val;
  logic [NREGS-1:0] pend_q, pend_d, pend_eff, wb_clr;
  logic             out_valid_q, out_valid_d;
  issue_bundle_t    bundle_q, bundle_d;

  assign op7     = instr[6:0];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign rd      = instr[11:7];
  assign legal   = is_legal(op7);
  assign use_rs1 = legal;
  assign use_rs2 = legal && uses_rs2(op7);

  decode_issue_regfile u_rf (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (rs1),
    .rb_addr (rs2),
    .ra_data (rs1_val),
    .rb_data (rs2_val),
    .wb_en   (wb_en),
    .wb_reg  (wb_reg),
    .wb_data (wb_data)
  );

  // One-hot clear mask from the writeback port.
  always_comb begin
    wb_clr = '0;
    if (wb_en) wb_clr[wb_reg] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  assign pend_eff = pend_q & ~wb_clr;
`else
  assign pend_eff = pend_q;
`endif

  assign hazard = (use_rs1 && pend_eff[rs1]) ||
                  (use_rs2 && pend_eff[rs2]) ||
                  (legal && (rd != 5'd0) && pend_eff[rd]);
  assign instr_ready = !hazard && (!out_valid_q || out_ready);
  assign accept      = instr_valid && instr_ready;

  // Scoreboard, valid and bundle next-state; a set beats a same-cycle clear.
  always_comb begin
    pend_d = pend_q & ~wb_clr;
    if (accept && legal && (rd != 5'd0)) pend_d[rd] = 1'b1;

    out_valid_d = out_valid_q;
    if (accept)         out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;

    bundle_d = bundle_q;
    if (accept) begin
      bundle_d.opcode      = {instr[14:12], op7};
      bundle_d.reg_a       = rs1;
      bundle_d.reg_b       = instr[31:20];
      bundle_d.reg_dest    = legal ? rd : 5'd0;
      bundle_d.reg_a_value = rs1_val;
      bundle_d.reg_b_value = use_rs2 ? rs2_val : '0;
      bundle_d.illegal     = !legal;
    end
  end

  // Control and bundle registers; reset discards any bundle in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign opcode     = bundle_q.opcode;
  assign regA       = bundle_q.reg_a;
  assign regB       = bundle_q.reg_b;
  assign regDest    = bundle_q.reg_dest;
  assign regA_value = bundle_q.reg_a_value;
  assign regB_value = bundle_q.reg_b_value;
  assign illegal    = bundle_q.illegal;

endmodule
